// File: rtl/mem_defs.sv
// Shared encodings for the MEM-stage store path and the load extraction block,
// so both ends of the data memory interface use one table.
package mem_defs;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SW   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SB   = 2'd3;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LW   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LHU  = 3'd3;
    localparam logic [2:0] LD_LB   = 3'd4;
    localparam logic [2:0] LD_LBU  = 3'd5;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational byte-enable, lane-replicated data and alignment check for one
// store request.
module store_lane_gen
    import mem_defs::*;
(
    input  logic [1:0]  sel_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    // Sub-word data is replicated across all lanes so the enables alone pick the target bytes.
    always_comb begin
        be_o       = '0;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        case (sel_i)
            ST_SW: begin
                be_o       = BE_ALL;
                misalign_o = (addr_lo_i != 2'b00);
            end
            ST_SH: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            ST_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{data_i[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Single-entry MEM-stage store buffer: accepts sw/sh/sb, holds one store until
// data memory acknowledges it, and forwards buffered bytes into same-word loads.
module store_buffer
    import mem_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_sel,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_misalign,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_word_in,
    output logic [DATA_W-1:0] ld_word_out,
    output logic              buf_empty
);

    localparam logic S_EMPTY = 1'b0;
    localparam logic S_FULL  = 1'b1;

    logic              state_q, state_d;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misalign_q;

    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic              lane_misalign;
    logic              accept, load, fwd_hit;
    logic              unused_ld_lo;

    store_lane_gen u_lane_gen (
        .sel_i      (st_sel),
        .addr_lo_i  (st_addr[1:0]),
        .data_i     (st_data),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_misalign)
    );

    assign buf_empty = (state_q == S_EMPTY);
    assign st_ready  = buf_empty | mem_ack;
    assign accept    = st_valid & (st_sel != ST_NONE) & st_ready;
    assign load      = accept & ~lane_misalign;

    // A retire and a new load at the same edge keep the buffer full with no gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (load) state_d = S_FULL;
            S_FULL:  if (mem_ack && !load) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= accept & lane_misalign;
            if (load) begin
                be_q    <= lane_be;
                addr_q  <= {st_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= lane_wdata;
            end
        end
    end

    assign mem_we      = (state_q == S_FULL);
    assign mem_be      = be_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign st_misalign = misalign_q;

    assign fwd_hit      = mem_we && (ld_addr[ADDR_W-1:2] == addr_q[ADDR_W-1:2]);
    assign unused_ld_lo = ^ld_addr[1:0];

    always_comb begin
        ld_word_out = ld_word_in;
        if (fwd_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) ld_word_out[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; expected stores go into a scoreboard queue
// when driven and are compared when the buffer presents them to memory.
module tb_store_buffer;
    import mem_defs::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } store_t;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_sel;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic [31:0] ld_word_in;
    logic [31:0] ld_word_out;
    logic        buf_empty;

    store_t expQ[$];
    int     checks   = 0;
    int     failures = 0;
    int     writes   = 0;
    int     writesBefore;

    store_buffer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_sel      (st_sel),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_misalign (st_misalign),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .ld_addr     (ld_addr),
        .ld_word_in  (ld_word_in),
        .ld_word_out (ld_word_out),
        .buf_empty   (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side write counter: a write happens only when we and ack coincide.
    always @(posedge clk) begin
        if (mem_we === 1'b1 && mem_ack === 1'b1) writes <= writes + 1;
    end

    function automatic logic [3:0] modelBe(input logic [1:0] sel, input logic [1:0] a);
        case (sel)
            ST_SW:   return 4'b1111;
            ST_SH:   return a[1] ? 4'b1100 : 4'b0011;
            ST_SB:   return 4'b0001 << a;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] modelData(input logic [1:0] sel, input logic [31:0] d);
        case (sel)
            ST_SH:   return {d[15:0], d[15:0]};
            ST_SB:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            default: return d;
        endcase
    endfunction

    function automatic bit modelLegal(input logic [1:0] sel, input logic [1:0] a);
        if (sel == ST_NONE) return 1'b0;
        if (sel == ST_SW && a != 2'b00) return 1'b0;
        if (sel == ST_SH && a[0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        store_t s;
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = a;
        st_data  = d;
        if (modelLegal(sel, a[1:0])) begin
            s.addr = {a[31:2], 2'b00};
            s.be   = modelBe(sel, a[1:0]);
            s.data = modelData(sel, d);
            expQ.push_back(s);
        end
    endtask

    task automatic idleStore();
        st_valid = 1'b0;
        st_sel   = ST_NONE;
    endtask

    // Bounded wait for the buffer to present a store, then compare against the queue head.
    task automatic checkStore(input string tag);
        store_t s;
        int     waited = 0;
        while (mem_we !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        if (mem_we !== 1'b1 || expQ.size() == 0) begin
            checkOutput({tag, "_present"}, {31'd0, mem_we}, 32'd1);
            return;
        end
        s = expQ.pop_front();
        checkOutput({tag, "_addr"}, mem_addr, s.addr);
        checkOutput({tag, "_be"}, {28'd0, mem_be}, {28'd0, s.be});
        checkOutput({tag, "_wdata"}, mem_wdata, s.data);
    endtask

    initial begin
        reset      = 1'b1;
        st_valid   = 1'b0;
        st_sel     = ST_NONE;
        st_addr    = '0;
        st_data    = '0;
        mem_ack    = 1'b0;
        ld_addr    = '0;
        ld_word_in = '0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_misalign", {31'd0, st_misalign}, 32'd0);
        checkOutput("rst_st_ready", {31'd0, st_ready}, 32'd1);

        // sb to the top byte, then a three-cycle memory stall
        applyStimulus(ST_SB, 32'h0000_1003, 32'h0000_00A5);
        tick();
        idleStore();
        checkStore("sb1003");
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_we", {31'd0, mem_we}, 32'd1);
            checkOutput("stall_addr", mem_addr, 32'h0000_1000);
            checkOutput("stall_be", {28'd0, mem_be}, 32'h8);
            checkOutput("stall_wdata", mem_wdata, 32'hA5A5_A5A5);
            checkOutput("stall_ready", {31'd0, st_ready}, 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        checkOutput("ack_ready", {31'd0, st_ready}, 32'd1);
        tick();
        mem_ack = 1'b0;
        checkOutput("retire_empty", {31'd0, buf_empty}, 32'd1);
        checkOutput("retire_we", {31'd0, mem_we}, 32'd0);
        checkOutput("retire_writes", writes, 32'd1);

        // sh to the upper half, retired, then a misaligned sw
        applyStimulus(ST_SH, 32'h0000_2002, 32'h1234_BEEF);
        tick();
        idleStore();
        checkStore("sh2002");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        applyStimulus(ST_SW, 32'h0000_2001, 32'hDEAD_BEEF);
        tick();
        idleStore();
        checkOutput("mis_pulse", {31'd0, st_misalign}, 32'd1);
        checkOutput("mis_we", {31'd0, mem_we}, 32'd0);
        checkOutput("mis_ready", {31'd0, st_ready}, 32'd1);
        tick();
        checkOutput("mis_pulse_end", {31'd0, st_misalign}, 32'd0);
        checkOutput("mis_still_empty", {31'd0, buf_empty}, 32'd1);

        // back-to-back replacement at the acknowledging edge
        applyStimulus(ST_SW, 32'h0000_0010, 32'h1111_1111);
        tick();
        idleStore();
        checkStore("sw10");
        applyStimulus(ST_SW, 32'h0000_0014, 32'h2222_2222);
        mem_ack = 1'b1;
        #1;
        checkOutput("b2b_ready", {31'd0, st_ready}, 32'd1);
        tick();
        idleStore();
        mem_ack = 1'b0;
        checkOutput("b2b_we", {31'd0, mem_we}, 32'd1);
        checkStore("sw14");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("b2b_empty", {31'd0, buf_empty}, 32'd1);

        // forwarding: not visible until the store sits in the buffer
        ld_addr    = 32'h0000_3000;
        ld_word_in = 32'hAABB_CCDD;
        applyStimulus(ST_SB, 32'h0000_3001, 32'h0000_007F);
        #1;
        checkOutput("fwd_not_yet", ld_word_out, 32'hAABB_CCDD);
        tick();
        idleStore();
        checkStore("sb3001");
        checkOutput("fwd_hit", ld_word_out, 32'hAABB_7FDD);
        ld_addr = 32'h0000_3004;
        #1;
        checkOutput("fwd_other_word", ld_word_out, 32'hAABB_CCDD);
        ld_addr = 32'h0000_3003;
        #1;
        checkOutput("fwd_same_word_hi", ld_word_out, 32'hAABB_7FDD);

        // reset while full discards the entry without a write
        writesBefore = writes;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstfull_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rstfull_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rstfull_empty", {31'd0, buf_empty}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("rstfull_no_write", writes, writesBefore);
        checkOutput("ack_ignored_empty", {31'd0, buf_empty}, 32'd1);

        // st_valid with no operation, on an address that would be misaligned
        st_valid = 1'b1;
        st_sel   = ST_NONE;
        st_addr  = 32'h0000_4001;
        st_data  = 32'h5555_5555;
        tick();
        idleStore();
        checkOutput("none_no_accept", {31'd0, buf_empty}, 32'd1);
        checkOutput("none_no_misalign", {31'd0, st_misalign}, 32'd0);
        checkOutput("none_we", {31'd0, mem_we}, 32'd0);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
MEM-stage store path of the MIPS pipeline; it is the write-side counterpart of the load extraction block.
- Accepts sw/sh/sb requests, checks alignment, and produces the word-aligned address, byte enables and lane-replicated write data.
- Holds one pending store in a single-entry buffer until data memory acknowledges it.
- Forwards buffered bytes into the raw word returned for a load to the same word, before that word reaches load extraction.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width; fixed at 32 and not validated for other values

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  store request present
- st_ready  out  1  request is accepted at this edge
- st_sel  in  2  0 none, 1 sw, 2 sh, 3 sb
- st_addr  in  32  byte address
- st_data  in  32  rt register value
- st_misalign  out  1  registered one-cycle pulse: a misaligned store was rejected
- mem_we  out  1  buffered store is presented to memory
- mem_be  out  4  byte enables; bit i covers data[8i+7:8i]
- mem_addr  out  32  word address, low two bits zero
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  memory commits the presented store at this edge
- ld_addr  in  32  address of the load in MEM
- ld_word_in  in  32  raw word read from memory
- ld_word_out  out  32  raw word with buffered bytes merged in
- buf_empty  out  1  no pending store

Behaviour:
- Reset values:
  - buffer invalid; buf_empty=1; mem_we=0
  - mem_be=0, mem_addr=0, mem_wdata=0
  - st_misalign=0
  - reset mid-operation discards any pending store with no write performed.
- Lane formation (combinational from st_*):
  - sw: be=1111, data=st_data.
  - sh: be = addr[1] ? 1100 : 0011; data={st_data[15:0],st_data[15:0]}.
  - sb: be = 0001 << addr[1:0]; data={4{st_data[7:0]}}.
  - Word address is {st_addr[31:2],2'b00}.
- Alignment:
  - sw requires addr[1:0]=00; sh requires addr[0]=0.
  - A violation is consumed without being buffered.
  - st_misalign goes high in the next cycle for exactly one cycle.
- st_ready = buf_empty | mem_ack (combinational).
- Acceptance: a store is accepted when st_valid & st_sel!=0 & st_ready at a rising edge.
  - A legal accepted request loads the buffer; mem_* take the new values in the next cycle.
  - st_valid with st_sel=0 is ignored and does not affect st_misalign.
- Buffer FSM with two states:
  - EMPTY -> FULL on a legal accept.
  - FULL -> EMPTY on mem_ack with no legal accept at the same edge.
  - FULL -> FULL with replacement on mem_ack and a legal accept at the same edge. The old entry retires and the new one loads; there is no gap cycle.
  - FULL with no mem_ack holds all mem_* stable. st_ready=0, and the upstream pipeline stalls.
- Memory port:
  - mem_we = buffer valid.
  - mem_be, mem_addr and mem_wdata are register outputs and change only at an accept or at reset.
  - mem_ack while mem_we=0 is ignored.
- Forwarding (combinational):
  - Forwarding applies when the buffer is valid and ld_addr[31:2] equals mem_addr[31:2].
  - In that case ld_word_out byte i = mem_be[i] ? mem_wdata byte i : ld_word_in byte i.
  - Otherwise ld_word_out = ld_word_in.
  - A store accepted at the current edge is not forwarded until it is in the buffer.
- Latency: one cycle from accept to mem_we; minimum one cycle in FULL before retire.

Decomposition:
- Package mem_defs holds:
  - the st_sel encodings: ST_NONE=0, ST_SW=1, ST_SH=2, ST_SB=3;
  - the load_sel encodings used by load extraction, so the two ends share one table;
  - BE_ALL=4'b1111.
- One sub-module, store_lane_gen: combinational be, data and misalign generation from sel and addr[1:0]. The buffer FSM and forwarding mux stay in the top module.

Test Plan:
- reset, then sb, addr 0x1003, data 0x000000A5 -> next cycle mem_we=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5; hold mem_ack=0 for 3 cycles -> outputs stable and st_ready=0; mem_ack=1 -> buf_empty=1 next cycle.
- sh, addr 0x2002, data 0x1234BEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF; sw, addr 0x2001 -> st_misalign pulse of exactly one cycle, mem_we stays 0, st_ready=1.
- Back-to-back: sw 0x10 with data 0x11111111, then sw 0x14 with data 0x22222222 at the same edge as mem_ack -> mem_addr goes 0x10 then 0x14 with mem_we continuously 1.
- Forwarding: buffer holds sb to 0x3001 with data 0x7F; ld_addr 0x3000, ld_word_in 0xAABBCCDD -> ld_word_out 0xAABB7FDD. With ld_addr 0x3004 -> ld_word_out passes ld_word_in unchanged.
- reset asserted while FULL and mem_ack=0 -> next cycle mem_we=0, mem_be=0, buf_empty=1, and no write is performed.
- st_valid=1, st_sel=0 -> no accept, no st_misalign, state unchanged.
